// File: rtl/sequenciador_permutacao_pkg.sv
// ---------------------------------------------------------------------------
// pkg_jogo
// Shared definitions for the game datapath: permutation word geometry, the
// sequencer state encoding and a helper that extracts one element of a
// packed permutation word. The permutation generator and the sequencer
// both rely on the same field ordering: element 0 lives in the MSBs.
// ---------------------------------------------------------------------------
package pkg_jogo;

  localparam int PERM_W = 8;
  localparam int IDX_W  = 2;
  localparam int N_ELEM = PERM_W / IDX_W;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ESPERA_PERM = 3'd1,
    EMITE       = 3'd2,
    FIM         = 3'd3,
    ERRO        = 3'd4
  } estado_t;

  // Element k of a permutation word; element 0 is the most significant field.
  function automatic logic [IDX_W-1:0] campo(input logic [PERM_W-1:0] p,
                                             input logic [1:0]        k);
    campo = p[PERM_W-1-IDX_W*int'(k) -: IDX_W];
  endfunction

endpackage

// File: rtl/sequenciador_permutacao_valida.sv
// ---------------------------------------------------------------------------
// valida_permutacao
// Purely combinational check that a packed permutation word is a valid
// ordering of 0..N_ELEM-1, i.e. all its fields are pairwise distinct.
// With four 2-bit fields, distinctness alone guarantees every value 0..3
// appears exactly once.
//
// Ports:
//   perm   in  PERM_W  permutation word, element 0 in the MSBs
//   valido out 1       high iff all fields are pairwise distinct
// ---------------------------------------------------------------------------
module valida_permutacao
  import pkg_jogo::*;
(
  input  logic [PERM_W-1:0] perm,
  output logic              valido
);

  // Compare every pair of fields once; any equal pair invalidates the word.
  always_comb begin
    valido = 1'b1;
    for (int a = 0; a < N_ELEM; a++) begin
      for (int b = a + 1; b < N_ELEM; b++) begin
        if (campo(perm, a[1:0]) == campo(perm, b[1:0])) begin
          valido = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sequenciador_permutacao.sv
// ---------------------------------------------------------------------------
// sequenciador_permutacao
// Consumer of the permutation-index generator. On a start request it keeps
// asking the upstream random source for words until the generator reports
// ready (or a timeout expires), captures the permutation, validates it and
// then hands out its four indices one per valid/ack handshake, each paired
// with a memory address {grupo, indice} for the memory read path.
//
// Parameters:
//   GRUPO_W         width of the memory group prefix (endereco = GRUPO_W+2)
//   MAX_TENTATIVAS  ESPERA_PERM cycles with perm_ready low before the
//                   timeout error fires (legal range 2..255)
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   synchronous, active-high reset
//   iniciar         in   start request, only looked at while idle
//   grupo           in   group prefix, latched when a start is accepted
//   perm            in   permutation from the generator
//   perm_ready      in   generator ready flag
//   avanca          in   consumer accepts the current index
//   pede_aleatorio  out  asks the upstream source for a new random word
//   indice          out  current permutation element
//   endereco        out  {latched grupo, indice}
//   indice_valido   out  indice/endereco are valid
//   ocupado         out  block is not idle
//   fim             out  one-cycle pulse after the 4th index is accepted
//   erro            out  one-cycle pulse on invalid permutation or timeout
// ---------------------------------------------------------------------------
module sequenciador_permutacao
  import pkg_jogo::*;
#(
  parameter int GRUPO_W        = 4,
  parameter int MAX_TENTATIVAS = 16
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [GRUPO_W-1:0]       grupo,
  input  logic [PERM_W-1:0]        perm,
  input  logic                     perm_ready,
  input  logic                     avanca,
  output logic                     pede_aleatorio,
  output logic [IDX_W-1:0]         indice,
  output logic [GRUPO_W+IDX_W-1:0] endereco,
  output logic                     indice_valido,
  output logic                     ocupado,
  output logic                     fim,
  output logic                     erro
);

  // The attempt counter only has to reach MAX_TENTATIVAS-1, and it is
  // cleared on every accepted start, so it never wraps.
  localparam int TENT_W = (MAX_TENTATIVAS > 2) ? $clog2(MAX_TENTATIVAS) : 1;
  localparam logic [TENT_W-1:0] TENT_ULTIMA = TENT_W'(MAX_TENTATIVAS - 1);

  estado_t             estado_q, estado_d;
  logic [PERM_W-1:0]   perm_q, perm_d;
  logic [GRUPO_W-1:0]  grupo_q, grupo_d;
  logic [1:0]          k_q, k_d;
  logic [TENT_W-1:0]   tent_q, tent_d;

  logic                     pede_q, pede_d;
  logic [IDX_W-1:0]         indice_q, indice_d;
  logic [GRUPO_W+IDX_W-1:0] endereco_q, endereco_d;
  logic                     valido_q, valido_d;
  logic                     ocupado_q, ocupado_d;
  logic                     fim_q, fim_d;
  logic                     erro_q, erro_d;

  logic perm_ok;

  valida_permutacao u_valida (
    .perm   (perm),
    .valido (perm_ok)
  );

  // Next-state logic. Everything defaults to holding, so EMITE under
  // backpressure and the data registers outside their load cycles keep
  // their values without extra terms.
  always_comb begin
    estado_d = estado_q;
    perm_d   = perm_q;
    grupo_d  = grupo_q;
    k_d      = k_q;
    tent_d   = tent_q;

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          grupo_d  = grupo;
          tent_d   = '0;
          estado_d = ESPERA_PERM;
        end
      end

      ESPERA_PERM: begin
        // A ready word wins over the timeout, even on the last attempt.
        if (perm_ready) begin
          if (perm_ok) begin
            perm_d   = perm;
            k_d      = 2'd0;
            estado_d = EMITE;
          end else begin
            estado_d = ERRO;
          end
        end else if (tent_q == TENT_ULTIMA) begin
          estado_d = ERRO;
        end else begin
          tent_d = tent_q + 1'b1;
        end
      end

      EMITE: begin
        if (avanca) begin
          if (k_q == 2'd3) begin
            estado_d = FIM;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end

      FIM:     estado_d = OCIOSO;
      ERRO:    estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Output values are decoded from the next state and next data so that,
  // once registered, they are a pure function of the current state: Moore
  // behaviour with no input-to-output path and no extra cycle of latency.
  always_comb begin
    pede_d     = (estado_d == ESPERA_PERM);
    ocupado_d  = (estado_d != OCIOSO);
    valido_d   = (estado_d == EMITE);
    fim_d      = (estado_d == FIM);
    erro_d     = (estado_d == ERRO);
    indice_d   = '0;
    endereco_d = '0;
    if (estado_d == EMITE) begin
      indice_d   = campo(perm_d, k_d);
      endereco_d = {grupo_d, campo(perm_d, k_d)};
    end
  end

  // State, data and output registers. Reset aborts any sequence silently:
  // outputs go straight to zero with no fim or erro pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      perm_q     <= '0;
      grupo_q    <= '0;
      k_q        <= '0;
      tent_q     <= '0;
      pede_q     <= 1'b0;
      indice_q   <= '0;
      endereco_q <= '0;
      valido_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      fim_q      <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      perm_q     <= perm_d;
      grupo_q    <= grupo_d;
      k_q        <= k_d;
      tent_q     <= tent_d;
      pede_q     <= pede_d;
      indice_q   <= indice_d;
      endereco_q <= endereco_d;
      valido_q   <= valido_d;
      ocupado_q  <= ocupado_d;
      fim_q      <= fim_d;
      erro_q     <= erro_d;
    end
  end

  assign pede_aleatorio = pede_q;
  assign indice         = indice_q;
  assign endereco       = endereco_q;
  assign indice_valido  = valido_q;
  assign ocupado        = ocupado_q;
  assign fim            = fim_q;
  assign erro           = erro_q;

endmodule

// File: tb/tb_sequenciador_permutacao.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_permutacao
// Self-checking bench for sequenciador_permutacao: a table of directed
// transactions with their expected indices, hand-written corner sequences
// (reset mid-emission, held start re-trigger) and randomized transactions
// whose expectations come from a transaction-level model.
// ---------------------------------------------------------------------------
module tb_sequenciador_permutacao;
  import pkg_jogo::*;

  localparam int GW  = 4;
  localparam int MAX = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic [GW-1:0]     grupo;
  logic [PERM_W-1:0] perm;
  logic              perm_ready;
  logic              avanca;
  logic              pede_aleatorio;
  logic [IDX_W-1:0]  indice;
  logic [GW+1:0]     endereco;
  logic              indice_valido;
  logic              ocupado;
  logic              fim;
  logic              erro;

  int nChecks = 0;
  int nFail   = 0;

  // One transaction: inputs plus the expected outcome. Per-element fields
  // are written with element 0 in the most significant slot.
  typedef struct {
    logic [GW-1:0]     grupo;
    logic [PERM_W-1:0] perm;
    int                waitCyc;
    logic [3:0][3:0]   stall;
    logic              expOk;
    logic [3:0][1:0]   expIdx;
  } vec_t;

  vec_t tbl[9];

  sequenciador_permutacao #(
    .GRUPO_W        (GW),
    .MAX_TENTATIVAS (MAX)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .grupo          (grupo),
    .perm           (perm),
    .perm_ready     (perm_ready),
    .avanca         (avanca),
    .pede_aleatorio (pede_aleatorio),
    .indice         (indice),
    .endereco       (endereco),
    .indice_valido  (indice_valido),
    .ocupado        (ocupado),
    .fim            (fim),
    .erro           (erro)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Advance one cycle and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  // Compare all outputs; indice/endereco only when careIdx is set.
  task automatic checkOutput(input string name, input logic ePede,
                             input logic eValid, input logic eOcup,
                             input logic eFim, input logic eErro,
                             input logic [1:0] eIdx, input logic [5:0] eEnd,
                             input logic careIdx);
    logic ok;
    nChecks++;
    ok = (pede_aleatorio === ePede) && (indice_valido === eValid) &&
         (ocupado === eOcup) && (fim === eFim) && (erro === eErro);
    if (careIdx) ok = ok && (indice === eIdx) && (endereco === eEnd);
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL %s: got pede=%0b vld=%0b ocp=%0b fim=%0b erro=%0b idx=%0d end=%h; want pede=%0b vld=%0b ocp=%0b fim=%0b erro=%0b idx=%0d end=%h",
               name, pede_aleatorio, indice_valido, ocupado, fim, erro, indice, endereco,
               ePede, eValid, eOcup, eFim, eErro, eIdx, eEnd);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1);
  endtask

  // Drive one complete transaction from idle back to idle, checking every
  // cycle. Inputs that must be ignored are scrambled while the block is busy.
  task automatic runTxn(input vec_t t, input string tag);
    int nPede;
    logic [1:0] e;
    iniciar    = 1'b1;
    grupo      = t.grupo;
    perm_ready = 1'b0;
    avanca     = 1'b0;
    perm       = PERM_W'($urandom);
    applyStimulus();
    nPede = (t.waitCyc >= MAX) ? MAX : t.waitCyc;
    for (int w = 0; w < nPede; w++) begin
      checkOutput({tag, " espera"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
      perm_ready = 1'b0;
      iniciar    = 1'($urandom);
      grupo      = GW'($urandom);
      applyStimulus();
    end
    iniciar = 1'b0;
    if (t.waitCyc >= MAX) begin
      checkOutput({tag, " timeout erro"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0);
      applyStimulus();
      checkIdle({tag, " idle apos timeout"});
      return;
    end
    checkOutput({tag, " espera pronto"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
    perm_ready = 1'b1;
    perm       = t.perm;
    applyStimulus();
    perm_ready = 1'b0;
    perm       = PERM_W'($urandom);
    if (!t.expOk) begin
      checkOutput({tag, " perm invalida erro"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0);
      applyStimulus();
      checkIdle({tag, " idle apos erro"});
      return;
    end
    for (int j = 0; j < 4; j++) begin
      e = t.expIdx[3-j];
      for (int s = 0; s < int'(t.stall[3-j]); s++) begin
        checkOutput({tag, " emite parado"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e, {t.grupo, e}, 1'b1);
        avanca  = 1'b0;
        iniciar = 1'($urandom);
        grupo   = GW'($urandom);
        perm    = PERM_W'($urandom);
        applyStimulus();
      end
      checkOutput({tag, " emite"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e, {t.grupo, e}, 1'b1);
      avanca  = 1'b1;
      iniciar = 1'b0;
      applyStimulus();
      avanca = 1'b0;
    end
    checkOutput({tag, " fim"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0);
    applyStimulus();
    checkIdle({tag, " idle apos fim"});
  endtask

  // Transaction-level reference: validity by counting distinct values,
  // elements by shifting the word, plus random wait/stall profile.
  function automatic vec_t makeRandom();
    vec_t t;
    int   a[4];
    int   tmp;
    int   r;
    int   f;
    int   distinct;
    bit   seen[4];
    t.grupo = GW'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < 4; i++) a[i] = i;
      for (int i = 3; i > 0; i--) begin
        r    = int'($urandom_range(0, i));
        tmp  = a[i];
        a[i] = a[r];
        a[r] = tmp;
      end
      t.perm = (a[0] * 64 + a[1] * 16 + a[2] * 4 + a[3]) & 8'hFF;
    end else begin
      t.perm = PERM_W'($urandom);
    end
    t.waitCyc = int'($urandom_range(0, MAX));
    distinct  = 0;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f = (int'(t.perm) >> (6 - 2 * i)) % 4;
      if (!seen[f]) distinct++;
      seen[f]         = 1'b1;
      t.expIdx[3-i]   = 2'(f);
      t.stall[3-i]    = 4'($urandom_range(0, 3));
    end
    t.expOk = (distinct == 4);
    return t;
  endfunction

  initial begin
    // Directed table: nominal, backpressure, invalid words, timeout and
    // the last-attempt boundary.
    tbl[0] = '{4'hA, 8'h1B, 0,  16'h0000, 1'b1, 8'h1B};
    tbl[1] = '{4'h5, 8'hE4, 0,  16'h5111, 1'b1, 8'hE4};
    tbl[2] = '{4'h3, 8'h00, 0,  16'h0000, 1'b0, 8'h00};
    tbl[3] = '{4'hF, 8'hFF, 2,  16'h0000, 1'b0, 8'h00};
    tbl[4] = '{4'h1, 8'h1A, 3,  16'h0000, 1'b0, 8'h00};
    tbl[5] = '{4'h7, 8'h1E, 15, 16'h1020, 1'b1, 8'h1E};
    tbl[6] = '{4'h0, 8'h39, 1,  16'h0301, 1'b1, 8'h39};
    tbl[7] = '{4'h9, 8'h1B, 16, 16'h0000, 1'b1, 8'h1B};
    tbl[8] = '{4'hC, 8'hB4, 4,  16'h2200, 1'b1, 8'hB4};

    reset      = 1'b1;
    iniciar    = 1'b0;
    grupo      = '0;
    perm       = '0;
    perm_ready = 1'b0;
    avanca     = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkIdle("reset");

    for (int i = 0; i < 9; i++) begin
      runTxn(tbl[i], $sformatf("tabela%0d", i));
    end

    // Reset after two indices have been accepted: silent abort.
    iniciar = 1'b1;
    grupo   = 4'h2;
    applyStimulus();
    iniciar = 1'b0;
    checkOutput("rst espera", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
    perm_ready = 1'b1;
    perm       = 8'h1B;
    applyStimulus();
    perm_ready = 1'b0;
    checkOutput("rst idx0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'h08, 1'b1);
    avanca = 1'b1;
    applyStimulus();
    checkOutput("rst idx1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 6'h09, 1'b1);
    applyStimulus();
    avanca = 1'b0;
    reset  = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkIdle("rst meio emite");
    applyStimulus();
    checkIdle("rst sem fim erro");
    runTxn(tbl[0], "apos reset");

    // iniciar held high across the end of a sequence re-triggers at once.
    iniciar    = 1'b1;
    grupo      = 4'h6;
    avanca     = 1'b1;
    applyStimulus();
    checkOutput("retrig espera", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
    perm_ready = 1'b1;
    perm       = 8'hE4;
    applyStimulus();
    for (int j = 0; j < 4; j++) begin
      checkOutput("retrig emite", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'(3 - j), {4'h6, 2'(3 - j)}, 1'b1);
      applyStimulus();
    end
    checkOutput("retrig fim", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0);
    perm_ready = 1'b0;
    applyStimulus();
    checkIdle("retrig ocioso");
    applyStimulus();
    checkOutput("retrig reinicia", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
    iniciar    = 1'b0;
    avanca     = 1'b0;
    perm_ready = 1'b1;
    perm       = 8'h00;
    applyStimulus();
    perm_ready = 1'b0;
    checkOutput("retrig erro", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0);
    applyStimulus();
    checkIdle("retrig final");

    for (int i = 0; i < 12; i++) begin
      runTxn(makeRandom(), $sformatf("aleatorio%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
